// File: rtl/dmni_rx_mux_buffer_pkg.sv
// rtl/dmni_rx_mux_buffer_pkg.sv - shared types and helpers for the DMNI multi-channel ingress buffer
package dmni_rx_mux_buffer_pkg;

    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

    localparam int TICK_W = 32;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dmni_rx_channel.sv
// rtl/dmni_rx_channel.sv - one ingress channel: flit ring plus per-packet EOP timestamp ring
module dmni_rx_channel
    import dmni_rx_mux_buffer_pkg::*;
#(
    parameter int FLIT_SIZE   = 32,
    parameter int BUFFER_SIZE = 16,
    parameter int TS_DEPTH    = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 push_i,
    input  logic                 eop_i,
    input  logic [FLIT_SIZE-1:0] data_i,
    input  logic [TICK_W-1:0]    tick_i,
    input  logic                 pop_i,
    output logic                 credit_o,
    output logic                 flit_empty_o,
    output logic                 head_eop_o,
    output logic [FLIT_SIZE-1:0] head_data_o,
    output logic [TICK_W-1:0]    ts_head_o
);

    localparam int FAW = $clog2(BUFFER_SIZE);
    localparam int TAW = $clog2(TS_DEPTH);

    logic [FLIT_SIZE:0]  flit_mem [BUFFER_SIZE];
    logic [TICK_W-1:0]   ts_mem   [TS_DEPTH];

    logic [FAW-1:0] f_wr, f_rd;
    logic [FAW:0]   f_cnt;
    logic [TAW-1:0] t_wr, t_rd;
    logic [TAW:0]   t_cnt;

    logic flit_full, ts_full;
    logic do_push, do_pop, ts_push, ts_pop;

    assign flit_full    = (f_cnt == (FAW+1)'(BUFFER_SIZE));
    assign ts_full      = (t_cnt == (TAW+1)'(TS_DEPTH));
    assign flit_empty_o = (f_cnt == '0);

    // Credit depends on registered counts only, so rx_i never reaches credit_o combinationally.
    assign credit_o = !flit_full && !ts_full;

    assign head_data_o = flit_mem[f_rd][FLIT_SIZE-1:0];
    assign head_eop_o  = flit_mem[f_rd][FLIT_SIZE];
    assign ts_head_o   = ts_mem[t_rd];

    assign do_push = push_i && credit_o && !flush_i;
    assign do_pop  = pop_i && !flush_i;
    assign ts_push = do_push && eop_i;
    assign ts_pop  = do_pop && head_eop_o;

    always_ff @(posedge clk_i) begin
        if (do_push) flit_mem[f_wr] <= {eop_i, data_i};
        if (ts_push) ts_mem[t_wr] <= tick_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            f_wr  <= '0;
            f_rd  <= '0;
            f_cnt <= '0;
            t_wr  <= '0;
            t_rd  <= '0;
            t_cnt <= '0;
        end else begin
            if (do_push) f_wr <= f_wr + FAW'(1);
            if (do_pop)  f_rd <= f_rd + FAW'(1);
            f_cnt <= f_cnt + {{FAW{1'b0}}, do_push} - {{FAW{1'b0}}, do_pop};
            if (ts_push) t_wr <= t_wr + TAW'(1);
            if (ts_pop)  t_rd <= t_rd + TAW'(1);
            t_cnt <= t_cnt + {{TAW{1'b0}}, ts_push} - {{TAW{1'b0}}, ts_pop};
        end
    end

    always @(posedge clk_i) begin
        if (!rst_i && !flush_i && pop_i) begin
            assert (f_cnt != '0);
            if (head_eop_o) assert (t_cnt != '0);
        end
    end

endmodule

// File: rtl/dmni_rx_mux_buffer.sv
// rtl/dmni_rx_mux_buffer.sv - N-channel Hermes ingress buffer with packet-atomic round-robin merge
module dmni_rx_mux_buffer
    import dmni_rx_mux_buffer_pkg::*;
#(
    parameter int FLIT_SIZE   = 32,
    parameter int BUFFER_SIZE = 16,
    parameter int TS_DEPTH    = 4,
    parameter int N_CHANNELS  = 2
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [TICK_W-1:0]               tick_counter_i,
    input  logic [N_CHANNELS-1:0]           flush_i,
    input  logic [N_CHANNELS-1:0]           rx_i,
    input  logic [N_CHANNELS-1:0]           eop_i,
    output logic [N_CHANNELS-1:0]           credit_o,
    input  logic [N_CHANNELS*FLIT_SIZE-1:0] data_i,
    output logic                            tx_o,
    output logic                            eop_o,
    input  logic                            ack_i,
    output logic [FLIT_SIZE-1:0]            data_o,
    output logic [clog2_min1(N_CHANNELS)-1:0] chan_o,
    output logic [TICK_W-1:0]               timestamp_o
);

    localparam int CW = clog2_min1(N_CHANNELS);

    logic [N_CHANNELS-1:0] flit_empty, head_eop, pop, req;
    logic [FLIT_SIZE-1:0]  head_data [N_CHANNELS];
    logic [TICK_W-1:0]     ts_head   [N_CHANNELS];

    arb_state_t     state;
    logic [CW-1:0]  grant, last_grant, next_grant;
    logic           found;

    for (genvar c = 0; c < N_CHANNELS; c++) begin : g_chan
        dmni_rx_channel #(
            .FLIT_SIZE  (FLIT_SIZE),
            .BUFFER_SIZE(BUFFER_SIZE),
            .TS_DEPTH   (TS_DEPTH)
        ) u_chan (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .flush_i     (flush_i[c]),
            .push_i      (rx_i[c]),
            .eop_i       (eop_i[c]),
            .data_i      (data_i[c*FLIT_SIZE +: FLIT_SIZE]),
            .tick_i      (tick_counter_i),
            .pop_i       (pop[c]),
            .credit_o    (credit_o[c]),
            .flit_empty_o(flit_empty[c]),
            .head_eop_o  (head_eop[c]),
            .head_data_o (head_data[c]),
            .ts_head_o   (ts_head[c])
        );

        assign pop[c] = tx_o && ack_i && (grant == CW'(c));
    end

    // A channel being flushed this cycle is not worth locking onto.
    assign req = ~flit_empty & ~flush_i;

    always_comb begin
        int idx;
        idx        = 0;
        found      = 1'b0;
        next_grant = last_grant;
        for (int i = 1; i <= N_CHANNELS; i++) begin
            idx = int'(last_grant) + i;
            if (idx >= N_CHANNELS) idx = idx - N_CHANNELS;
            if (!found && req[idx[CW-1:0]]) begin
                found      = 1'b1;
                next_grant = CW'(idx);
            end
        end
    end

    always_comb begin
        tx_o        = 1'b0;
        eop_o       = 1'b0;
        data_o      = '0;
        chan_o      = '0;
        timestamp_o = '0;
        if (state == ARB_LOCKED) begin
            tx_o        = !flit_empty[grant];
            eop_o       = head_eop[grant];
            data_o      = head_data[grant];
            chan_o      = grant;
            timestamp_o = head_eop[grant] ? ts_head[grant] : '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= ARB_IDLE;
            grant      <= '0;
            last_grant <= CW'(N_CHANNELS - 1);
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (found) begin
                        grant <= next_grant;
                        state <= ARB_LOCKED;
                    end
                end
                ARB_LOCKED: begin
                    // Packet end or flush both release the lock; a flush truncates downstream.
                    if (flush_i[grant] || (tx_o && ack_i && eop_o)) begin
                        last_grant <= grant;
                        state      <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmni_rx_mux_buffer.sv
// tb/tb_dmni_rx_mux_buffer.sv - scoreboard bench for the multi-channel DMNI ingress buffer
module tb_dmni_rx_mux_buffer;

    localparam int NCH = 2;
    localparam int BS  = 16;
    localparam int TSD = 4;

    typedef struct {logic eop; logic [31:0] data; logic [31:0] ts;} exp_t;
    typedef struct {int cyc; int chan; logic eop;} log_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [31:0]     tick;
    logic [NCH-1:0]  flush = '0, rx = '0, eop_in = '0, credit;
    logic [NCH*32-1:0] data_in = '0;
    logic            tx, eop_out, ack = 1'b0;
    logic [31:0]     data_out, ts;
    logic [0:0]      chan;

    exp_t exp_q [NCH][$];
    log_t pop_log[$];
    int   n_checks = 0, n_fail = 0, cyc = 0;
    logic drv_done [NCH];
    logic t6_done = 1'b0;

    dmni_rx_mux_buffer #(.FLIT_SIZE(32), .BUFFER_SIZE(BS), .TS_DEPTH(TSD), .N_CHANNELS(NCH)) dut (
        .clk_i(clk), .rst_i(rst), .tick_counter_i(tick), .flush_i(flush), .rx_i(rx),
        .eop_i(eop_in), .credit_o(credit), .data_i(data_in), .tx_o(tx), .eop_o(eop_out),
        .ack_i(ack), .data_o(data_out), .chan_o(chan), .timestamp_o(ts)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign tick = 32'd100 + 32'(cyc) * 32'd3;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic model_credit(input int c);
        int ne = 0;
        for (int i = 0; i < exp_q[c].size(); i++) if (exp_q[c][i].eop) ne++;
        return (exp_q[c].size() < BS) && (ne < TSD);
    endfunction

    function automatic int total_q();
        int t = 0;
        for (int c = 0; c < NCH; c++) t += exp_q[c].size();
        return t;
    endfunction

    // Monitor / scoreboard: everything that commits at the next edge is judged here.
    logic in_pkt = 1'b0, hold_v = 1'b0, hold_eop;
    int   pkt_chan = 0, hold_chan;
    logic [31:0] hold_data, hold_ts;
    logic [NCH-1:0] cr;
    exp_t e;
    always @(negedge clk) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) exp_q[c].delete();
            in_pkt = 1'b0;
            hold_v = 1'b0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                cr[c] = model_credit(c);
                check("credit", {31'd0, credit[c]}, {31'd0, cr[c]});
            end
            if (hold_v) begin
                check("hold_tx", {31'd0, tx}, 32'd1);
                check("hold_data", data_out, hold_data);
                check("hold_eop", {31'd0, eop_out}, {31'd0, hold_eop});
                check("hold_chan", {31'd0, chan}, hold_chan);
                check("hold_ts", ts, hold_ts);
            end
            if (tx && !eop_out) check("ts_zero_no_eop", ts, 32'd0);
            if (tx && ack) begin
                if (in_pkt) check("atomic_chan", {31'd0, chan}, pkt_chan);
                check("pop_nonempty", {31'd0, exp_q[int'(chan)].size() != 0}, 32'd1);
                if (exp_q[int'(chan)].size() != 0) begin
                    e = exp_q[int'(chan)].pop_front();
                    check("data", data_out, e.data);
                    check("eop", {31'd0, eop_out}, {31'd0, e.eop});
                    if (e.eop) check("timestamp", ts, e.ts);
                end
                pop_log.push_back('{cyc, int'(chan), eop_out});
                in_pkt   = !eop_out;
                pkt_chan = int'(chan);
            end
            hold_v    = tx && !ack && !flush[chan];
            hold_data = data_out;
            hold_eop  = eop_out;
            hold_chan = int'(chan);
            hold_ts   = ts;
            for (int c = 0; c < NCH; c++) begin
                if (flush[c]) begin
                    exp_q[c].delete();
                    if (in_pkt && pkt_chan == c) in_pkt = 1'b0;
                end else if (rx[c] && cr[c]) begin
                    exp_q[c].push_back('{eop_in[c], data_in[c*32 +: 32], tick});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int c, input logic [31:0] d, input logic e);
        logic ok;
        int   n = 0;
        rx[c] = 1'b1;
        eop_in[c] = e;
        data_in[c*32 +: 32] = d;
        forever begin
            @(negedge clk);
            ok = credit[c];
            step();
            if (ok) break;
            n++;
            if (n > 2000) begin
                n_checks++;
                n_fail++;
                $display("FAIL send_timeout chan=%0d actual=blocked required=accepted", c);
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; rx = '0; flush = '0; ack = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic drain();
        ack = 1'b1;
        for (int k = 0; k < 3000 && (total_q() != 0 || tx); k++) step();
        @(negedge clk);
        check("drain_left", total_q(), 32'd0);
        step();
    endtask

    task automatic rand_driver(input int c);
        int len;
        repeat (30) begin
            repeat ($urandom_range(0, 3)) step();
            if ($urandom_range(0, 15) == 0) begin
                flush[c] = 1'b1;
                step();
                flush[c] = 1'b0;
            end
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) send(c, $urandom, i == len - 1);
            rx[c] = 1'b0;
        end
        drv_done[c] = 1'b1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        drv_done[0] = 1'b0;
        drv_done[1] = 1'b0;
        do_reset();
        @(negedge clk);
        check("rst_tx", {31'd0, tx}, 32'd0);
        check("rst_eop", {31'd0, eop_out}, 32'd0);
        check("rst_data", data_out, 32'd0);
        check("rst_chan", {31'd0, chan}, 32'd0);
        check("rst_ts", ts, 32'd0);
        check("rst_credit", {30'd0, credit}, 32'd3);
        step();

        // 1: three-flit packet, two-cycle latency from IDLE
        ack = 1'b1;
        fork
            begin
                send(0, 32'hA1, 1'b0); send(0, 32'hA2, 1'b0); send(0, 32'hA3, 1'b1);
                rx[0] = 1'b0;
            end
            begin
                @(negedge clk); check("t1_lat_c0", {31'd0, tx}, 32'd0);
                @(negedge clk); check("t1_lat_c1", {31'd0, tx}, 32'd0);
                @(negedge clk); check("t1_lat_c2", {31'd0, tx}, 32'd1);
            end
        join
        drain();

        // 2: round robin between two loaded channels, one IDLE cycle between packets
        do_reset();
        pop_log.delete();
        ack = 1'b0;
        fork
            begin
                send(0, 32'h20, 0); send(0, 32'h21, 1); send(0, 32'h22, 0); send(0, 32'h23, 1);
                rx[0] = 1'b0;
            end
            begin
                send(1, 32'h30, 0); send(1, 32'h31, 1); send(1, 32'h32, 0); send(1, 32'h33, 1);
                rx[1] = 1'b0;
            end
        join
        drain();
        check("t2_count", pop_log.size(), 32'd8);
        if (pop_log.size() == 8) begin
            for (int i = 0; i < 8; i++) check("t2_order", pop_log[i].chan, (i / 2) % 2);
            check("t2_gap_a", pop_log[2].cyc - pop_log[1].cyc, 32'd2);
            check("t2_gap_b", pop_log[4].cyc - pop_log[3].cyc, 32'd2);
        end

        // 3: fill ch1 without eop, one pop restores credit
        ack = 1'b0;
        for (int i = 0; i < 16; i++) send(1, 32'h3000 + i, 1'b0);
        rx[1] = 1'b0;
        @(negedge clk);
        check("t3_full", {31'd0, credit[1]}, 32'd0);
        step();
        send(0, 32'h5000, 1'b0); send(0, 32'h5001, 1'b1);
        rx[0] = 1'b0;
        ack = 1'b1;
        step();
        ack = 1'b0;
        @(negedge clk);
        check("t3_credit_back", {31'd0, credit[1]}, 32'd1);

        // 5: flush while locked mid-packet on ch1, ch0 is granted next
        step();
        flush[1] = 1'b1;
        step();
        flush[1] = 1'b0;
        @(negedge clk);
        check("t5_idle", {31'd0, tx}, 32'd0);
        check("t5_credit1", {31'd0, credit[1]}, 32'd1);
        @(negedge clk);
        check("t5_tx", {31'd0, tx}, 32'd1);
        check("t5_chan", {31'd0, chan}, 32'd0);
        step();
        drain();

        // 4: four single-flit packets fill the timestamp ring
        ack = 1'b0;
        for (int i = 0; i < 4; i++) send(0, 32'h4000 + i, 1'b1);
        rx[0] = 1'b0;
        @(negedge clk);
        check("t4_ts_full", {31'd0, credit[0]}, 32'd0);
        step();
        drain();

        // 6: continuous rx across pointer wrap with toggling ack
        pop_log.delete();
        fork
            begin
                for (int i = 0; i < 40; i++) send(0, 32'h6000 + i, (i % 8) == 7);
                rx[0] = 1'b0;
                for (int k = 0; k < 2000 && pop_log.size() < 40; k++) step();
                t6_done = 1'b1;
            end
            begin
                while (!t6_done) begin
                    ack = !ack;
                    step();
                end
            end
        join
        check("t6_count", pop_log.size(), 32'd40);
        drain();

        // Randomized traffic with occasional flushes
        fork
            rand_driver(0);
            rand_driver(1);
            begin
                for (int k = 0; k < 20000 && !(drv_done[0] && drv_done[1]); k++) begin
                    ack = ($urandom_range(0, 9) < 7);
                    step();
                end
            end
        join
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
